// File: rtl/sift_pkg.sv
// sift_pkg: shared definitions for the SIFT descriptor-matching blocks.
//   dist_w()    : width of a descriptor SAD (element width + log2 element count)
//   desc_bits() : width of a packed descriptor
//   state_t     : matcher control-state encoding
//   RATIO_*_DEF : default Lowe ratio (0.8 = 4/5)
package sift_pkg;

  localparam int RATIO_NUM_DEF = 4;
  localparam int RATIO_DEN_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  function automatic int dist_w(input int desc_w, input int desc_n);
    return desc_w + $clog2(desc_n);
  endfunction

  function automatic int desc_bits(input int desc_w, input int desc_n);
    return desc_w * desc_n;
  endfunction

endpackage

// File: rtl/sift_sad.sv
// sift_sad: combinational sum of absolute differences between two packed
// descriptors of DESC_N unsigned DESC_W-bit elements.
//   i_a, i_b : packed descriptors, element k at [k*DESC_W +: DESC_W]
//   o_sad    : sum over k of |a_k - b_k|, DIST_W bits (cannot overflow)
module sift_sad
  import sift_pkg::*;
#(
  parameter  int DESC_W = 8,
  parameter  int DESC_N = 16,
  localparam int DIST_W = dist_w(DESC_W, DESC_N),
  localparam int DW     = desc_bits(DESC_W, DESC_N)
) (
  input  logic [DW-1:0]     i_a,
  input  logic [DW-1:0]     i_b,
  output logic [DIST_W-1:0] o_sad
);

  // Elements are unsigned; widen by one bit so the difference is an exact
  // signed value before taking its magnitude.
  function automatic logic [DESC_W-1:0] abs_diff(input logic [DESC_W-1:0] a,
                                                 input logic [DESC_W-1:0] b);
    logic signed [DESC_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[DESC_W] ? DESC_W'(-d) : d[DESC_W-1:0];
  endfunction

  always_comb begin
    o_sad = '0;
    for (int k = 0; k < DESC_N; k++) begin
      o_sad = o_sad + DIST_W'(abs_diff(i_a[k*DESC_W +: DESC_W], i_b[k*DESC_W +: DESC_W]));
    end
  end

endmodule

// File: rtl/sift_desc_matcher.sv
// sift_desc_matcher: buffers up to DEPTH reference descriptors (image 1); for
// each query descriptor (image 2) scans every stored reference by SAD, keeps
// the best and second-best distance, and emits one ratio-tested result.
//   clk, rst (async, active-low), clear (sync flush)
//   desc_valid/desc_ready/desc_set/desc_addr/desc_data : descriptor input
//   match_valid/match_ready/match_hit/match_addr/match_dist : result output
//   ref_count : stored references, overflow : sticky reference-while-full
module sift_desc_matcher
  import sift_pkg::*;
#(
  parameter  int DESC_W    = 8,
  parameter  int DESC_N    = 16,
  parameter  int DEPTH     = 64,
  parameter  int AW        = 16,
  parameter  int RATIO_NUM = RATIO_NUM_DEF,
  parameter  int RATIO_DEN = RATIO_DEN_DEF,
  localparam int DIST_W    = dist_w(DESC_W, DESC_N),
  localparam int DW        = desc_bits(DESC_W, DESC_N),
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic              desc_set,
  input  logic [AW-1:0]     desc_addr,
  input  logic [DW-1:0]     desc_data,
  output logic              match_valid,
  input  logic              match_ready,
  output logic              match_hit,
  output logic [2*AW-1:0]   match_addr,
  output logic [DIST_W-1:0] match_dist,
  output logic [CW-1:0]     ref_count,
  output logic              overflow
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW = (RATIO_NUM > RATIO_DEN) ? $clog2(RATIO_NUM) : $clog2(RATIO_DEN);
  localparam int PW = DIST_W + RW + 1;
  localparam logic [CW-1:0]     FULL = CW'(DEPTH);
  localparam logic [DIST_W-1:0] ONES = '1;

  // best*DEN < second*NUM at a width that holds both products exactly.
  function automatic logic ratio_pass(input logic [DIST_W-1:0] best,
                                      input logic [DIST_W-1:0] second);
    logic [PW-1:0] lhs;
    logic [PW-1:0] rhs;
    lhs = PW'(best) * PW'(RATIO_DEN);
    rhs = PW'(second) * PW'(RATIO_NUM);
    return lhs < rhs;
  endfunction

  state_t              r_state, w_state_nxt;
  logic [AW-1:0]       r_ref_addr [DEPTH];
  logic [DW-1:0]       r_ref_data [DEPTH];
  logic [AW-1:0]       r_q_addr;
  logic [DW-1:0]       r_q_data;
  logic [CW-1:0]       r_idx_p0;
  logic [IW-1:0]       w_rd_idx;
  logic [DIST_W-1:0]   w_sad;
  logic [DIST_W-1:0]   r_sad_p1;
  logic [IW-1:0]       r_idx_p1;
  logic                r_vld_p1;
  logic [DIST_W-1:0]   r_best, r_second;
  logic [IW-1:0]       r_best_idx;
  logic                w_ref_acc, w_qry_acc, w_ovf, w_issue, w_done, w_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // w_done waits for the registered SAD pipe to drain so the final compare
  // has landed in r_best/r_second before the result is captured.
  always_comb begin
    w_state_nxt = r_state;
    desc_ready  = 1'b0;
    w_ref_acc   = 1'b0;
    w_qry_acc   = 1'b0;
    w_ovf       = 1'b0;
    w_issue     = 1'b0;
    w_done      = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        desc_ready = !clear && (desc_set || (ref_count < FULL));
        w_ref_acc  = desc_valid && desc_ready && !desc_set;
        w_qry_acc  = desc_valid && desc_ready && desc_set;
        w_ovf      = desc_valid && !desc_set && (ref_count == FULL);
        if (w_qry_acc) w_state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        w_issue = r_idx_p0 < ref_count;
        w_done  = !w_issue && !r_vld_p1;
        if (w_done) w_state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        w_pop = match_ready;
        if (match_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (clear) w_state_nxt = ST_IDLE;
  end

  assign w_rd_idx = r_idx_p0[IW-1:0];

  // stage p0: reference selected by r_idx_p0, SAD against the latched query
  sift_sad #(.DESC_W(DESC_W), .DESC_N(DESC_N)) u_sad (
    .i_a   (r_q_data),
    .i_b   (r_ref_data[w_rd_idx]),
    .o_sad (w_sad)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_count   <= '0;
      overflow    <= 1'b0;
      match_valid <= 1'b0;
      match_hit   <= 1'b0;
      match_addr  <= '0;
      match_dist  <= '0;
      r_vld_p1    <= 1'b0;
    end else if (clear) begin
      ref_count   <= '0;
      overflow    <= 1'b0;
      match_valid <= 1'b0;
      r_vld_p1    <= 1'b0;
    end else begin
      if (w_ref_acc) ref_count <= ref_count + 1'b1;
      if (w_ovf)     overflow  <= 1'b1;
      r_vld_p1 <= w_issue;
      if (w_done) begin
        match_valid <= 1'b1;
        match_hit   <= (ref_count != '0) && ratio_pass(r_best, r_second);
        match_addr  <= {r_q_addr, (ref_count != '0) ? r_ref_addr[r_best_idx] : AW'(0)};
        match_dist  <= r_best;
      end else if (w_pop) begin
        match_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_ref_acc) begin
      r_ref_addr[ref_count[IW-1:0]] <= desc_addr;
      r_ref_data[ref_count[IW-1:0]] <= desc_data;
    end
    if (w_qry_acc) begin
      r_q_addr   <= desc_addr;
      r_q_data   <= desc_data;
      r_idx_p0   <= '0;
      r_best     <= ONES;
      r_second   <= ONES;
      r_best_idx <= '0;
    end
    if (w_issue) begin
      r_sad_p1 <= w_sad;
      r_idx_p1 <= w_rd_idx;
      r_idx_p0 <= r_idx_p0 + 1'b1;
    end
    // stage p1: registered SAD ranked; strict compares keep the lowest index on ties
    if (r_vld_p1) begin
      if (r_sad_p1 < r_best) begin
        r_second   <= r_best;
        r_best     <= r_sad_p1;
        r_best_idx <= r_idx_p1;
      end else if (r_sad_p1 < r_second) begin
        r_second <= r_sad_p1;
      end
    end
  end

endmodule

// File: doc/sift_desc_matcher.md
Name: sift_desc_matcher

Overview:
- Parametrised successor to the pixel-stream matcher in the SIFT fuse pipeline.
- Buffers up to DEPTH reference keypoint descriptors from image 1.
- For each query descriptor from image 2, scans all stored references by SAD, then applies a Lowe-style ratio test.
- Emits one result per query: {query_addr, ref_addr}, distance and hit flag, through a valid/ready output.

Parameters:
- DESC_W, 8: bits per descriptor element (unsigned).
- DESC_N, 16: elements per descriptor.
- DEPTH, 64: max stored reference descriptors.
- AW, 16: keypoint pixel-address width (256x256 frame).
- RATIO_NUM, 4: ratio-test numerator.
- RATIO_DEN, 5: ratio-test denominator (threshold 0.8).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush: empties buffer, aborts scan, drops result
- desc_valid  in  1  descriptor offered
- desc_ready  out  1  descriptor accepted when valid&&ready
- desc_set  in  1  0 = reference (image 1), 1 = query (image 2)
- desc_addr  in  AW  keypoint pixel address
- desc_data  in  DESC_N*DESC_W  packed descriptor; element k at [k*DESC_W +: DESC_W]
- match_valid  out  1  result available
- match_ready  in  1  result consumed when valid&&ready
- match_hit  out  1  1 = ratio test passed
- match_addr  out  2*AW  {query_addr, ref_addr}
- match_dist  out  DIST_W  best SAD, DIST_W = DESC_W+$clog2(DESC_N) (12)
- ref_count  out  $clog2(DEPTH+1)  stored references
- overflow  out  1  sticky: reference offered while buffer full

Behaviour:
- Reset (rst=0): state IDLE, ref_count=0, overflow=0, match_valid=0, match_hit=0, match_addr=0, match_dist=0. Buffer contents are don't-care.
- States: IDLE -> SCAN -> EMIT -> IDLE.
- IDLE, desc_ready rule: desc_ready = desc_set ? 1 : (ref_count<DEPTH).
- IDLE, set-0 accept: write {addr,data} to entry ref_count; ref_count++. Stay in IDLE. References and queries may interleave; later queries see appended entries.
- IDLE, set-0 offered with ref_count==DEPTH: desc_ready=0 and overflow<=1 (sticky until clear/rst).
- IDLE, set-1 accept at edge E0: latch query {addr,data}; idx=0; best=second=all-ones; best_idx=0; go to SCAN.
- SCAN: one reference per cycle. SAD(idx) = sum over k of |q_k - r_k|, computed combinationally and registered once (1-stage pipe). Registered SAD is compared on the next cycle.
  - Update rule: if sad<best then second<=best, best<=sad, best_idx<=i; else if sad<second then second<=sad.
  - Ties keep the lowest index.
  - After the last compare, go to EMIT.
- SCAN with ref_count==0: zero compares; go straight to EMIT.
- Latency: match_valid rises on edge E0+ref_count+2, or E0+1 when ref_count==0.
- EMIT outputs:
  - match_valid=1
  - match_addr={q_addr, ref_addr[best_idx]}, with ref_addr=0 if no refs
  - match_dist=best
  - match_hit=(ref_count>0) && (best*RATIO_DEN < second*RATIO_NUM), evaluated at full product width DIST_W+$clog2(max(NUM,DEN))+1, no truncation.
- EMIT hold: outputs stable while match_ready=0. On valid&&ready, match_valid<=0 and return to IDLE.
- desc_ready=0 in SCAN and EMIT.
- clear=1, any state: next edge gives ref_count=0, overflow=0, match_valid=0, state IDLE. clear has priority over an accept in the same cycle. desc_ready=0 while clear=1.
- Single-reference case: second stays all-ones, so the hit depends only on the product compare.

Decomposition:
- Shared package sift_pkg: DIST_W function, packed descriptor width, state encoding localparams, ratio defaults.
- One sub-module: sift_sad, combinational DESC_N-element abs-diff adder tree, DIST_W-bit output. It is reused by later SIFT stages.
- Reference store: distributed register array, read combinationally by idx.

Test Plan:
- Clear hit: refs A0=all 0x10 @0x0101, A1=all 0x40 @0x0202; query all 0x12 @0x0303 -> match_hit=1, match_addr=0x03030101, match_dist=32, match_valid at E0+4.
- Ambiguous tie: refs all 0x10 and all 0x14; query all 0x12 -> dist 32 for both; hit=0 (160<128 false); ref_addr = index 0 address.
- Empty buffer: query with ref_count=0 -> match_valid at E0+1, hit=0, match_dist=0xFFF, ref_addr=0.
- Full/overflow: load 64 refs, offer 65th -> desc_ready=0, overflow=1, ref_count=64. Query still accepted; scan latency 66.
- Backpressure: hold match_ready=0 for 10 cycles -> outputs stable, desc_ready=0. Release -> one transfer only, back to IDLE.
- Abort: clear mid-SCAN (ref_count=5) -> next cycle match_valid stays 0, ref_count=0, overflow=0. Async rst mid-EMIT -> all outputs at reset values immediately.
